// File: rtl/i2c_init_sequencer_pkg.sv
// Shared types for the I2C init sequencer, the byte master and the board table ROM.
package i2c_init_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] OP_DELAY = 8'hFE;
    localparam logic [7:0] OP_END   = 8'hFF;

    typedef struct packed {
        logic [7:0] op_dev;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } entry_t;

    function automatic logic is_write(input logic [7:0] op);
        return !op[7];
    endfunction

endpackage

// File: rtl/i2c_init_sequencer_timer.sv
// Loadable down-counter with a zero flag; paces both programmed delays and retry gaps.
module i2c_init_sequencer_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the external register-write table through the I2C byte master after reset.
// state | meaning: IDLE wait start | FETCH rom read | DECODE branch on op | ISSUE cmd_valid
//   | WAIT xfer result | GAP retry pause | DELAY programmed wait | NEXT advance | DONE/ERROR set flag
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter int unsigned N_ENTRIES   = 64,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned DELAY_TICKS = 50000,
    parameter int unsigned RETRY_GAP   = 500,
    localparam int unsigned IW = $clog2(N_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [IW-1:0] tbl_addr,
    input  logic [23:0]   tbl_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [6:0]    cmd_dev,
    output logic [7:0]    cmd_reg,
    output logic [7:0]    cmd_data,
    input  logic          xfer_done,
    input  logic          xfer_nack,
    output logic          busy,
    output logic          init_done,
    output logic          init_err,
    output logic [IW-1:0] err_index
);

    // Timer is sized for the longest of a 255-unit delay and the retry gap.
    localparam int unsigned DELAY_MAX = 255 * DELAY_TICKS;
    localparam int unsigned TIMER_MAX = (DELAY_MAX > RETRY_GAP) ? DELAY_MAX : RETRY_GAP;
    localparam int unsigned TW        = $clog2(TIMER_MAX + 1);
    localparam int unsigned RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ENTRIES - 1);

    state_t          state, state_nxt;
    entry_t          entry;
    logic [RW-1:0]   retry;
    logic            can_retry;
    logic            timer_load;
    logic [TW-1:0]   timer_val;
    logic            timer_zero;

    assign entry     = entry_t'(tbl_data);
    assign can_retry = (32'(retry) < MAX_RETRY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_write(entry.op_dev)) begin
                    state_nxt = S_ISSUE;
                end else if (entry.op_dev == OP_END) begin
                    state_nxt = S_DONE;
                end else if (entry.op_dev == OP_DELAY) begin
                    state_nxt = (entry.data == '0) ? S_NEXT : S_DELAY;
                end else begin
                    state_nxt = S_NEXT;
                end
            end
            S_ISSUE:  if (cmd_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (xfer_done) begin
                    if (!xfer_nack)     state_nxt = S_NEXT;
                    else if (can_retry) state_nxt = S_GAP;
                    else                state_nxt = S_ERROR;
                end
            end
            S_GAP:    if (timer_zero) state_nxt = S_ISSUE;
            S_DELAY:  if (timer_zero) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = (tbl_addr == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:   state_nxt = S_IDLE;
            S_ERROR:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid  = (state == S_ISSUE);
        busy       = (state != S_IDLE);
        timer_load = 1'b0;
        timer_val  = '0;
        if (state == S_DECODE && entry.op_dev == OP_DELAY) begin
            timer_load = 1'b1;
            timer_val  = TW'(entry.data) * TW'(DELAY_TICKS);
        end else if (state == S_WAIT && xfer_done && xfer_nack && can_retry) begin
            timer_load = 1'b1;
            timer_val  = TW'(RETRY_GAP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_addr  <= '0;
            cmd_dev   <= '0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= '0;
            retry     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tbl_addr  <= '0;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        err_index <= '0;
                        retry     <= '0;
                    end
                end
                S_DECODE: begin
                    if (is_write(entry.op_dev)) begin
                        cmd_dev  <= entry.op_dev[6:0];
                        cmd_reg  <= entry.reg_addr;
                        cmd_data <= entry.data;
                    end
                end
                S_WAIT: begin
                    if (xfer_done) begin
                        if (!xfer_nack)     retry     <= '0;
                        else if (can_retry) retry     <= retry + 1'b1;
                        else                err_index <= tbl_addr;
                    end
                end
                S_NEXT:  if (tbl_addr != LAST_IDX) tbl_addr <= tbl_addr + 1'b1;
                S_DONE:  init_done <= 1'b1;
                S_ERROR: init_err  <= 1'b1;
                default: ;
            endcase
        end
    end

    i2c_init_sequencer_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

endmodule
